udp_tx_arbiter: RTL and testbench
=================================

// Module: udp_tx_arbiter
// PURPOSE
// - Packet-granular round-robin arbiter that shares the single udp_top user write stream
//   (wr_data/wr_valid/wr_last/wr_ready) between NUM_SRC packetised sources such as ADC capture or test generators.
// - Prefixes each granted packet with one header word (source id + global sequence number).
// - Caps packet length at MAX_PKT_WORDS; an over-long packet is truncated and its remainder drained.
// - Sits in the 200 MHz write domain, between the sources and udp_top.
// PARAMETERS
// - NUM_SRC        2     number of requesting sources, 2..8
// - DATA_W         32    stream width, >=32
// - MAX_PKT_WORDS  1024  maximum payload words per packet, excluding the header; >=2
// - HDR_EN         1     1 = emit header word, 0 = pure arbiter
// PORTS
// - i_Sys_clk    in   1               system clock (write domain)
// - i_Rst_n      in   1               reset, asynchronous, active-low
// - i_enable     in   1               1 = arbitration allowed; sampled only in IDLE
// - s_data       in   NUM_SRC*DATA_W  source data, src k at [k*DATA_W +: DATA_W]
// - s_valid      in   NUM_SRC         source valid
// - s_last       in   NUM_SRC         source end-of-packet
// - s_ready      out  NUM_SRC         source ready
// - m_data       out  DATA_W          to udp_top wr_data
// - m_valid      out  1               to udp_top wr_valid
// - m_last       out  1               to udp_top wr_last
// - m_ready      in   1               from udp_top wr_ready
// - o_grant      out  NUM_SRC         one-hot current owner; 0 in IDLE
// - o_busy       out  1               1 in any state other than IDLE
// - o_pkt_cnt    out  16              packets emitted, wraps 0xFFFF->0
// - o_trunc_err  out  1               sticky: a packet was truncated; cleared only by reset
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0, seq=0, word_cnt=0, last_grant=NUM_SRC-1 (src0 wins first).
// - Handshake: transfer occurs when valid & ready are both high in the same cycle.
//   - m_valid must not depend on m_ready.
//   - Once m_valid rises, m_data/m_last stay stable until the transfer.
// - IDLE
//   - Leaves IDLE when i_enable=1 and s_valid!=0.
//   - Grant goes to the first requester searching from last_grant+1 upward, modulo NUM_SRC.
//   - Grant is registered: o_grant is valid from the next cycle.
//   - Next state is HDR if HDR_EN=1, otherwise DATA.
// - HDR
//   - m_valid=1, m_last=0, all s_ready=0.
//   - m_data = zero-extended {8'hA5, 8'(src_id), seq[15:0]}.
//   - On transfer, go to DATA.
// - DATA
//   - Zero-latency combinational pass-through of the granted source g:
//     m_data=s_data[g], m_valid=s_valid[g], s_ready[g]=m_ready; other s_ready are 0.
//   - m_last = s_last[g] | (word_cnt==MAX_PKT_WORDS-1).
//   - word_cnt increments on each transfer.
//   - Transfer with m_last: seq++, o_pkt_cnt++, last_grant<=g, word_cnt<=0.
//     - If s_last[g]=1, go to IDLE.
//     - If s_last[g]=0 (forced end), set o_trunc_err and go to DROP.
// - DROP
//   - m_valid=0, s_ready[g]=1; source words are discarded.
//   - On a source handshake with s_last[g]=1, go to IDLE. Truncated remainder is not counted.
// - Boundaries
//   - A packet of exactly MAX_PKT_WORDS words with s_last on the final word is not a truncation.
//   - A single-word packet is legal: HDR then one DATA word with last.
//   - i_enable falling mid-packet has no effect; the current packet completes and the block then holds in IDLE.
//   - A requester whose s_valid drops in DATA keeps the grant (no timeout).
//   - seq and o_pkt_cnt wrap silently.
//   - Asynchronous reset mid-packet: immediate return to reset values; the downstream sees a truncated
//     packet without last, and recovery is the responsibility of the udp_top reset.
// STRUCTURE
// - Shared include udp_defs.vh holds:
//   - HDR_MAGIC = 8'hA5
//   - state encodings ST_IDLE/ST_HDR/ST_DATA/ST_DROP (2-bit)
//   - header field offsets
// - Sub-module rr_arbiter #(N):
//   - combinational, inputs req[N] and last_grant index, output one-hot gnt[N] plus its index;
//   - instantiated once here and reusable by other stream muxes.
// - The FSM, counters and output mux stay in udp_tx_arbiter.
// TESTING
// 1. Single source: src0 sends 4 words 0x10..0x13 with m_ready=1.
//    Expect: m stream A5000000,10,11,12,13; m_last on 0x13; o_pkt_cnt=1.
// 2. Fairness: src0 and src1 both hold requests continuously.
//    Expect: grants alternate 0,1,0,1; header seq fields 0,1,2,3.
// 3. Backpressure: m_ready toggles every cycle during a 3-word packet.
//    Expect: no data loss or duplication; m_data stable while m_valid=1 and m_ready=0.
// 4. Truncation: MAX_PKT_WORDS=4, src1 sends 6 words.
//    Expect: m_last on word 4; o_trunc_err=1; words 5-6 drained with m_valid=0; next packet starts normally.
// 5. Enable and reset: i_enable=0 with src0 valid.
//    Expect: no grant; after a mid-packet i_enable drop, the packet still completes.
//    Asserting i_Rst_n=0 mid-DATA returns all outputs to 0 in the same cycle.
// 6. Exact length: MAX_PKT_WORDS=4 and a 4-word packet with s_last on word 4.
//    Expect: o_trunc_err stays 0; FSM returns to IDLE.

Source files
------------

// File: rtl/udp_tx_arbiter_pkg.sv
// rtl/udp_tx_arbiter_pkg.sv - shared constants, FSM states and header builder for udp_tx_arbiter
//
// Purpose : header magic, 2-bit state encodings and header field offsets shared by the
//           arbiter top and anything that decodes its header word.
// Ports   : none (package).

package udp_tx_arbiter_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Header word layout (low 32 bits; wider streams are zero-extended above)
    localparam int HDR_SEQ_LSB   = 0;
    localparam int HDR_SEQ_W     = 16;
    localparam int HDR_SRC_LSB   = 16;
    localparam int HDR_SRC_W     = 8;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_MAGIC_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    function automatic logic [31:0] make_hdr(input logic [HDR_SRC_W-1:0] src,
                                             input logic [HDR_SEQ_W-1:0] seq);
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: HDR_MAGIC_W] = HDR_MAGIC;
        h[HDR_SRC_LSB   +: HDR_SRC_W]   = src;
        h[HDR_SEQ_LSB   +: HDR_SEQ_W]   = seq;
        return h;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// rtl/udp_tx_arbiter_rr_arbiter.sv - combinational round-robin requester picker
//
// Purpose : picks the first asserted request searching upward from i_last_grant+1,
//           wrapping modulo N. Reusable by any stream mux.
// Ports   : i_req        N    request vector
//           i_last_grant IW   index of the previous owner
//           o_gnt        N    one-hot winner (0 when no request)
//           o_gnt_idx    IW   binary index of the winner
//           o_any        1    at least one request present

module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    int   w_k;
    logic w_found;

    assign o_any = |i_req;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_k       = 0;
        // i runs 1..N so the previous owner is checked last
        for (int i = 1; i <= N; i++) begin
            w_k = int'(i_last_grant) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_gnt[w_k]   = 1'b1;
                o_gnt_idx    = IW'(w_k);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - packet-granular round-robin arbiter onto the udp_top write stream
//
// Purpose : shares one write stream between NUM_SRC packet sources, prefixes each packet
//           with a header word (magic, source id, sequence), caps payload length at
//           MAX_PKT_WORDS and drains the remainder of over-long packets.
// Ports   : i_Sys_clk, i_Rst_n (async, active-low), i_enable (sampled in IDLE)
//           s_data/s_valid/s_last/s_ready   per-source input streams
//           m_data/m_valid/m_last/m_ready   output stream to udp_top
//           o_grant (one-hot owner), o_busy, o_pkt_cnt (wrapping), o_trunc_err (sticky)

module udp_tx_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int DATA_W        = 32,
    parameter int MAX_PKT_WORDS = 1024,
    parameter int HDR_EN        = 1
) (
    input  logic                      i_Sys_clk,
    input  logic                      i_Rst_n,
    input  logic                      i_enable,
    input  logic [NUM_SRC*DATA_W-1:0] s_data,
    input  logic [NUM_SRC-1:0]        s_valid,
    input  logic [NUM_SRC-1:0]        s_last,
    output logic [NUM_SRC-1:0]        s_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic [NUM_SRC-1:0]        o_grant,
    output logic                      o_busy,
    output logic [15:0]               o_pkt_cnt,
    output logic                      o_trunc_err
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(MAX_PKT_WORDS);

    state_t              r_state;
    logic [NUM_SRC-1:0]  r_grant;
    logic [IW-1:0]       r_gidx;
    logic [IW-1:0]       r_last_grant;
    logic [15:0]         r_seq;
    logic [CW-1:0]       r_word_cnt;
    logic [15:0]         r_pkt_cnt;
    logic                r_trunc_err;

    logic [NUM_SRC-1:0]  w_gnt;
    logic [IW-1:0]       w_gnt_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_src_data;
    logic                w_src_valid;
    logic                w_src_last;
    logic                w_cap;
    logic [DATA_W-1:0]   w_hdr;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .i_req        (s_valid),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt),
        .o_gnt_idx    (w_gnt_idx),
        .o_any        (w_any)
    );

    assign w_src_data  = s_data[int'(r_gidx)*DATA_W +: DATA_W];
    assign w_src_valid = s_valid[r_gidx];
    assign w_src_last  = s_last[r_gidx];
    // Word counter sits on the last allowed payload word: force the end of the packet
    assign w_cap       = (r_word_cnt == CW'(MAX_PKT_WORDS - 1));
    assign w_hdr       = DATA_W'(make_hdr(8'(r_gidx), r_seq));

    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_trunc_err = r_trunc_err;

    // Output mux: header comes from registers, so it is stable until accepted;
    // DATA is a zero-latency pass-through of the owner.
    always_comb begin
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        s_ready = '0;
        case (r_state)
            ST_HDR: begin
                m_data  = w_hdr;
                m_valid = 1'b1;
            end
            ST_DATA: begin
                m_data  = w_src_data;
                m_valid = w_src_valid;
                m_last  = w_src_last | w_cap;
                s_ready = r_grant & {NUM_SRC{m_ready}};
            end
            ST_DROP: begin
                s_ready = r_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_grant <= IW'(NUM_SRC - 1);
            r_seq        <= '0;
            r_word_cnt   <= '0;
            r_pkt_cnt    <= '0;
            r_trunc_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable && w_any) begin
                        r_grant    <= w_gnt;
                        r_gidx     <= w_gnt_idx;
                        r_word_cnt <= '0;
                        r_state    <= (HDR_EN != 0) ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (m_ready) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_src_valid && m_ready) begin
                        if (w_src_last || w_cap) begin
                            r_seq        <= r_seq + 16'd1;
                            r_pkt_cnt    <= r_pkt_cnt + 16'd1;
                            r_last_grant <= r_gidx;
                            r_word_cnt   <= '0;
                            if (w_src_last) begin
                                r_state <= ST_IDLE;
                                r_grant <= '0;
                            end else begin
                                r_trunc_err <= 1'b1;
                                r_state     <= ST_DROP;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + CW'(1);
                        end
                    end
                end
                ST_DROP: begin
                    // s_ready is held high here, so any valid word is consumed
                    if (w_src_valid && w_src_last) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - self-checking bench for udp_tx_arbiter

module tb_udp_tx_arbiter;

    localparam int NS   = 3;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              en    = 1'b0;
    logic [NS*DW-1:0]  s_data;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_last;
    logic [NS-1:0]     s_ready;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic [NS-1:0]     o_grant;
    logic              o_busy;
    logic [15:0]       o_pkt_cnt;
    logic              o_trunc_err;

    udp_tx_arbiter #(
        .NUM_SRC(NS), .DATA_W(DW), .MAX_PKT_WORDS(MAXW), .HDR_EN(1)
    ) dut (
        .i_Sys_clk  (clk),
        .i_Rst_n    (rst_n),
        .i_enable   (en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .o_grant    (o_grant),
        .o_busy     (o_busy),
        .o_pkt_cnt  (o_pkt_cnt),
        .o_trunc_err(o_trunc_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Per-source word store: {last, data}
    logic [32:0] mem [NS][256];
    int          wr_ptr [NS];
    int          rd_ptr [NS];
    bit          in_pkt [NS];
    bit [NS-1:0] fired;
    bit          drv_en  = 0;
    int          rdy_mode = 0;
    logic [32:0] obs_q [$];
    logic [32:0] exp_q [$];
    bit          hold_pend = 0;
    logic [32:0] hold_w;

    // Reference model state
    int mdl_last  = NS - 1;
    int mdl_seq   = 0;
    int mdl_pkt   = 0;
    bit mdl_trunc = 0;

    // Source drivers and output monitor
    initial begin
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b0;
        for (int k = 0; k < NS; k++) begin
            wr_ptr[k] = 0; rd_ptr[k] = 0; in_pkt[k] = 0;
        end
        forever begin
            @(negedge clk);
            fired = '0;
            if (rst_n) begin
                for (int k = 0; k < NS; k++) begin
                    if (s_valid[k] && s_ready[k]) begin
                        fired[k]  = 1'b1;
                        in_pkt[k] = !mem[k][rd_ptr[k] % 256][32];
                        rd_ptr[k]++;
                    end
                end
                if (hold_pend) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_word", {m_last, m_data}, hold_w);
                end
                hold_pend = m_valid && !m_ready;
                hold_w    = {m_last, m_data};
                if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
            end else begin
                hold_pend = 0;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (!drv_en || rd_ptr[k] == wr_ptr[k]) s_valid[k] = 1'b0;
                else if (s_valid[k] && !fired[k])      s_valid[k] = 1'b1;
                else if (!in_pkt[k])                   s_valid[k] = 1'b1;
                else                                   s_valid[k] = ($urandom_range(0, 2) != 0);
                s_data[k*DW +: DW] = mem[k][rd_ptr[k] % 256][31:0];
                s_last[k]          = mem[k][rd_ptr[k] % 256][32];
            end
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    task automatic load_pkt(input int src, input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            mem[src][wr_ptr[src] % 256] = {(i == len - 1), 32'(base + i)};
            wr_ptr[src]++;
        end
    endtask

    // Expected output from packet-level rules: round robin over sources with
    // pending packets, header then up to MAXW words, last forced on the cap.
    task automatic build_expected();
        int          p [NS];
        int          src;
        int          n;
        int          c;
        bit          more;
        bit          fin;
        logic [32:0] w;
        exp_q.delete();
        for (int k = 0; k < NS; k++) p[k] = rd_ptr[k];
        more = 1;
        while (more) begin
            src = -1;
            for (int i = 1; i <= NS; i++) begin
                c = (mdl_last + i) % NS;
                if (src < 0 && p[c] < wr_ptr[c]) src = c;
            end
            if (src < 0) begin
                more = 0;
            end else begin
                exp_q.push_back({1'b0, 8'hA5, 8'(src), 16'(mdl_seq)});
                n   = 0;
                fin = 0;
                while (!fin) begin
                    w = mem[src][p[src] % 256];
                    p[src]++;
                    n++;
                    if (n <= MAXW) exp_q.push_back({(w[32] || n == MAXW), w[31:0]});
                    fin = w[32];
                end
                if (n > MAXW) mdl_trunc = 1;
                mdl_seq  = (mdl_seq + 1) % 65536;
                mdl_pkt  = (mdl_pkt + 1) % 65536;
                mdl_last = src;
            end
        end
    endtask

    task automatic run_batch(input string tag, input int mode, input bit drop_en);
        int cyc;
        bit done;
        bit seen_busy;
        int gs;
        bit all_empty;
        rdy_mode = mode;
        build_expected();
        obs_q.delete();
        drv_en    = 1;
        en        = 1;
        cyc       = 0;
        done      = 0;
        seen_busy = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            #2;
            cyc++;
            if (!seen_busy && o_busy) begin
                seen_busy = 1;
                if (exp_q.size() > 0) begin
                    gs = int'(exp_q[0][23:16]);
                    check({tag, " grant"}, o_grant, 64'(1) << gs);
                end
                if (drop_en) en = 0;
            end
            all_empty = 1;
            for (int k = 0; k < NS; k++) if (rd_ptr[k] != wr_ptr[k]) all_empty = 0;
            done = all_empty && !o_busy;
        end
        drv_en = 0;
        check({tag, " done"}, done, 1);
        if (exp_q.size() > 0) check({tag, " busy_seen"}, seen_busy, 1);
        check({tag, " nwords"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s word%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, " pkt_cnt"}, o_pkt_cnt, 16'(mdl_pkt));
        check({tag, " trunc"}, o_trunc_err, mdl_trunc);
        check({tag, " grant_idle"}, o_grant, 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst m_valid", m_valid, 0);
        check("rst m_last", m_last, 0);
        check("rst m_data", m_data, 0);
        check("rst s_ready", s_ready, 0);
        check("rst grant", o_grant, 0);
        check("rst busy", o_busy, 0);
        check("rst pkt_cnt", o_pkt_cnt, 0);
        check("rst trunc", o_trunc_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single source, exact-length packet: not a truncation
        load_pkt(0, 4, 32'h10);
        run_batch("single", 0, 0);
        if (obs_q.size() > 0) check("single hdr", obs_q[0], {1'b0, 32'hA500_0000});
        check("single trunc0", o_trunc_err, 0);

        // Fairness: two sources with two packets each
        load_pkt(0, 2, 32'h0100_0000);
        load_pkt(0, 2, 32'h0100_0100);
        load_pkt(1, 2, 32'h0200_0000);
        load_pkt(1, 2, 32'h0200_0100);
        run_batch("fair", 0, 0);

        // Backpressure with m_ready toggling every cycle
        load_pkt(2, 3, 32'h0300_0000);
        run_batch("bp", 1, 0);

        // Truncation then a normal packet
        load_pkt(1, 6, 32'h0200_0200);
        load_pkt(2, 3, 32'h0300_0100);
        run_batch("trunc", 0, 0);

        // Disabled: a pending request gets no grant
        load_pkt(0, 3, 32'h0100_0200);
        drv_en = 1;
        en     = 0;
        repeat (10) @(negedge clk);
        #2;
        check("dis grant", o_grant, 0);
        check("dis busy", o_busy, 0);
        check("dis s_ready", s_ready, 0);
        // Enable dropped right after the grant: packet still completes
        run_batch("endrop", 1, 1);
        load_pkt(1, 2, 32'h0200_0300);
        drv_en = 1;
        repeat (8) @(negedge clk);
        #2;
        check("hold idle busy", o_busy, 0);
        run_batch("reen", 0, 0);

        // Randomized batches
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < NS; k++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int j = 0; j < np; j++)
                    load_pkt(k, $urandom_range(1, 7),
                             {8'(k + 1), 8'($urandom_range(0, 255)), 16'h0});
            end
            run_batch($sformatf("rnd%0d", b), $urandom_range(0, 2), 0);
        end

        // Asynchronous reset in the middle of DATA
        load_pkt(2, 4, 32'h0300_0200);
        rdy_mode = 0;
        obs_q.delete();
        drv_en = 1;
        en     = 1;
        cyc    = 0;
        while (obs_q.size() < 2 && cyc < 200) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("mid reached", obs_q.size() >= 2, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst m_valid", m_valid, 0);
        check("arst m_last", m_last, 0);
        check("arst s_ready", s_ready, 0);
        check("arst grant", o_grant, 0);
        check("arst busy", o_busy, 0);
        check("arst pkt_cnt", o_pkt_cnt, 0);
        check("arst trunc", o_trunc_err, 0);
        drv_en = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NS; k++) begin
            rd_ptr[k] = 0; wr_ptr[k] = 0; in_pkt[k] = 0;
        end
        mdl_last  = NS - 1;
        mdl_seq   = 0;
        mdl_pkt   = 0;
        mdl_trunc = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        load_pkt(1, 2, 32'h0200_0400);
        run_batch("post_rst", 0, 0);
        if (obs_q.size() > 0) check("post_rst hdr", obs_q[0], {1'b0, 32'hA501_0000});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
